// File: rtl/seg_pkg.sv
// Shared codes and active-low glyphs for the seven-segment display path.
package seg_pkg;

  typedef enum logic [1:0] {
    SLOT0 = 2'd0,
    SLOT1 = 2'd1,
    SLOT2 = 2'd2,
    SLOT3 = 2'd3
  } slot_t;

  localparam logic [3:0] CODE_BLANK = 4'hA;
  localparam logic [3:0] CODE_DASH  = 4'hB;

  // Segment order {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

endpackage

// File: rtl/seg_decode.sv
// Combinational digit code to active-low glyph.
// code: 4-bit digit code; seg: {g,f,e,d,c,b,a}, active-low.
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (code)
      4'd0:      seg = SEG_0;
      4'd1:      seg = SEG_1;
      4'd2:      seg = SEG_2;
      4'd3:      seg = SEG_3;
      4'd4:      seg = SEG_4;
      4'd5:      seg = SEG_5;
      4'd6:      seg = SEG_6;
      4'd7:      seg = SEG_7;
      4'd8:      seg = SEG_8;
      4'd9:      seg = SEG_9;
      CODE_DASH: seg = SEG_DASH;
      default:   seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seven_seg_driver.sv
// Time-multiplexed 4-digit common-anode seven-segment driver.
// nums/blink_mask/dp_mask are captured at frame boundaries only.
// digit: active-low anodes; display: {g,f,e,d,c,b,a} active-low; dp active-low.
module seven_seg_driver
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 100000,
  parameter int unsigned GUARD        = 16,
  parameter int unsigned BLINK_FRAMES = 125
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] nums,
  input  logic [3:0]  blink_mask,
  input  logic [3:0]  dp_mask,
  output logic [3:0]  digit,
  output logic [6:0]  display,
  output logic        dp
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [DIV_W-1:0] div_cnt;
  slot_t            slot;
  logic [FRM_W-1:0] frame_cnt;
  logic             blink_phase;

  logic [15:0] sh_nums;
  logic [3:0]  sh_blink;
  logic [3:0]  sh_dp;

  logic       slot_end;
  logic       frame_end;
  logic       frame_wrap;
  logic       dark;
  logic [3:0] cur_code;
  logic [6:0] cur_glyph;

  assign slot_end   = (div_cnt == DIV_W'(SCAN_DIV - 1));
  assign frame_end  = slot_end && (slot == SLOT3);
  assign frame_wrap = (frame_cnt == FRM_W'(BLINK_FRAMES - 1));

  always_comb begin
    cur_code = sh_nums[3:0];
    case (slot)
      SLOT0: cur_code = sh_nums[3:0];
      SLOT1: cur_code = sh_nums[7:4];
      SLOT2: cur_code = sh_nums[11:8];
      SLOT3: cur_code = sh_nums[15:12];
      default: cur_code = sh_nums[3:0];
    endcase
  end

  always_comb begin
    dark = (div_cnt < DIV_W'(GUARD)) || (sh_blink[slot] && blink_phase);
  end

  seg_decode u_decode (
    .code (cur_code),
    .seg  (cur_glyph)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt     <= '0;
      slot        <= SLOT0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      div_cnt <= slot_end ? '0 : div_cnt + 1'b1;
      if (slot_end) slot <= slot_t'(slot + 2'd1);
      if (frame_end) begin
        frame_cnt <= frame_wrap ? '0 : frame_cnt + 1'b1;
        if (frame_wrap) blink_phase <= ~blink_phase;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_nums  <= {4{CODE_BLANK}};
      sh_blink <= '0;
      sh_dp    <= '0;
    end else if (frame_end) begin
      sh_nums  <= nums;
      sh_blink <= blink_mask;
      sh_dp    <= dp_mask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit   <= '1;
      display <= SEG_OFF;
      dp      <= 1'b1;
    end else if (dark) begin
      digit   <= '1;
      display <= SEG_OFF;
      dp      <= 1'b1;
    end else begin
      digit   <= ~(4'b0001 << slot);
      display <= cur_glyph;
      dp      <= ~sh_dp[slot];
    end
  end

endmodule

// File: tb/tb_seven_seg_driver.sv
`timescale 1ns/1ps
module tb_seven_seg_driver;

  logic        clk;
  logic        rst_n;
  logic [15:0] nums;
  logic [3:0]  blink_mask;
  logic [3:0]  dp_mask;
  logic [3:0]  digit;
  logic [6:0]  display;
  logic        dp;

  int unsigned checks = 0;
  int unsigned errors = 0;

  seven_seg_driver #(
    .SCAN_DIV     (8),
    .GUARD        (2),
    .BLINK_FRAMES (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .nums       (nums),
    .blink_mask (blink_mask),
    .dp_mask    (dp_mask),
    .digit      (digit),
    .display    (display),
    .dp         (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-written glyph table, {g,f,e,d,c,b,a} active-low.
  function automatic logic [6:0] glyph(input logic [3:0] code);
    case (code)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      4'hB: return 7'b0111111;
      default: return 7'b1111111;
    endcase
  endfunction

  // Expected shadow contents per frame index of the directed sequence.
  function automatic logic [15:0] frame_nums(input int unsigned f);
    if (f == 0) return 16'hAAAA;
    if (f == 1) return 16'h1234;
    if (f == 2) return 16'h5678;
    return 16'hAB0A;
  endfunction

  function automatic logic [3:0] frame_blink(input int unsigned f);
    return (f >= 3) ? 4'b0001 : 4'b0000;
  endfunction

  function automatic logic [3:0] frame_dp(input int unsigned f);
    return (f >= 3) ? 4'b0010 : 4'b0000;
  endfunction

  task automatic chk_digit(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_disp(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Output after edge k reflects counter value c = k-1 from the previous cycle.
  task automatic check_cycle(input int unsigned k);
    int unsigned c, f, s, d;
    logic        ph, drk;
    logic [15:0] sh;
    logic [3:0]  bm, dm, e_dig, code;
    logic [6:0]  e_disp;
    logic        e_dp;
    c  = k - 1;
    f  = c / 32;
    s  = (c / 8) % 4;
    d  = c % 8;
    ph = ((f / 2) % 2) == 1;
    sh = frame_nums(f);
    bm = frame_blink(f);
    dm = frame_dp(f);
    code = sh[4*s +: 4];
    drk  = (d < 2) || (bm[s] && ph);
    e_dig  = drk ? 4'hF : ~(4'b0001 << s);
    e_disp = drk ? 7'h7F : glyph(code);
    e_dp   = drk ? 1'b1 : ~dm[s];
    chk_digit($sformatf("digit k=%0d", k), digit, e_dig);
    chk_disp($sformatf("display k=%0d", k), display, e_disp);
    chk_bit($sformatf("dp k=%0d", k), dp, e_dp);
    checks++;
    assert ($countones(~digit) <= 1) else begin
      errors++;
      $error("FAIL onehot k=%0d: got %b expected at most one low", k, digit);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    nums       = 16'h1234;
    blink_mask = 4'b0000;
    dp_mask    = 4'b0000;

    repeat (3) @(negedge clk);
    chk_digit("reset digit", digit, 4'hF);
    chk_disp("reset display", display, 7'h7F);
    chk_bit("reset dp", dp, 1'b1);
    rst_n = 1'b1;

    // Frames 0..7 plus part of frame 8.
    for (int unsigned k = 1; k <= 268; k++) begin
      @(posedge clk);
      @(negedge clk);
      check_cycle(k);
      if (k == 44) nums = 16'h5678;        // mid-slot 1 of frame 1: must not leak
      if (k == 95) begin                   // changes right before the capture edge
        nums       = 16'hAB0A;
        blink_mask = 4'b0001;
        dp_mask    = 4'b0010;
      end
    end

    // Async reset pulse during slot 1's active window of frame 8.
    #2 rst_n = 1'b0;
    #0.5;
    chk_digit("async digit", digit, 4'hF);
    chk_disp("async display", display, 7'h7F);
    chk_bit("async dp", dp, 1'b1);
    #0.5 rst_n = 1'b1;

    // After reset the shadow is blank again for a whole frame.
    for (int unsigned k = 1; k <= 32; k++) begin
      @(posedge clk);
      @(negedge clk);
      check_cycle(k);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_seg_driver.md
# seven_seg_driver

Time-multiplexed driver for the board's 4-digit, common-anode seven-segment display. It is the consumer end of the 16-bit `nums` digit bus produced by the timer and score logic: four 4-bit digit codes (0–9 plus special codes such as blank `4'hA`). It scans one digit at a time at a divided rate and inserts an anode-off guard interval at each slot change to suppress ghosting. Input is captured only at frame boundaries so a frame never mixes old and new values, and selected digits can be blinked and given a decimal point.

## Interface
- `SCAN_DIV`, 100000: clk cycles per digit slot (1 kHz slot rate at 100 MHz); must be > `GUARD`.
- `GUARD`, 16: cycles at the start of each slot with all anodes off.
- `BLINK_FRAMES`, 125: frames per blink half-period (≈0.5 s at defaults).
- `clk` in 1: system clock, single clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `nums` in 16: digit codes. `nums[15:12]` is the leftmost digit (slot 3); `nums[3:0]` is the rightmost (slot 0).
- `blink_mask` in 4: bit s=1 means slot s blinks.
- `dp_mask` in 4: bit s=1 means the decimal point is lit on slot s.
- `digit` out 4: anodes, active-low; `digit[s]` drives slot s.
- `display` out 7: segments `{g,f,e,d,c,b,a}`, active-low.
- `dp` out 1: decimal point, active-low.

## Operation
- Code map:
  - 0–9 → decimal glyphs, e.g. 0 = `7'b1000000`, 1 = `7'b1111001`, 8 = `7'b0000000`.
  - `4'hA` → blank (`7'b1111111`).
  - `4'hB` → dash (`7'b0111111`).
  - `4'hC`–`4'hF` → blank.
- Counters:
  - `div_cnt` counts 0..`SCAN_DIV`-1, then wraps.
  - `slot` (2 bits) increments when `div_cnt` wraps, order 0→1→2→3→0.
  - `frame_cnt` counts 0..`BLINK_FRAMES`-1 and increments on each frame boundary.
  - `blink_phase` toggles when `frame_cnt` wraps.
- Frame boundary: the edge where `div_cnt==SCAN_DIV-1` and `slot==3`. On that edge `nums`, `blink_mask` and `dp_mask` load into shadow registers. Inputs are ignored at all other times.
- Slot s is dark (anodes off, `display` = blank, `dp`=1) when either condition holds:
  - `div_cnt < GUARD`;
  - shadow `blink_mask[s]`=1 and `blink_phase`=1.
- Otherwise, in slot s:
  - `digit = ~(4'b0001 << s)`;
  - `display` = glyph of shadow code s;
  - `dp = ~shadow dp_mask[s]`.
- Reset values:
  - `digit=4'b1111`, `display=7'b1111111`, `dp=1`;
  - shadow `nums=16'hAAAA`, shadow masks = 0;
  - all counters = 0, `blink_phase=0` (visible).
- Boundary behaviour:
  - Reset asserted mid-frame returns all outputs to reset values immediately (asynchronous).
  - The first frame after reset shows all-blank; the first capture happens at the end of that frame.
  - A `nums` change coinciding with the capture edge is captured (sampled value at that edge).
  - A frame boundary coinciding with a blink wrap toggles the phase and applies the new masks together.

## Timing
- All outputs are registered and derived from counter values of the previous cycle, so outputs lag counters by exactly 1 cycle.
- Slot s anode assertion: `digit[s]` first goes low on the edge after `div_cnt` reaches `GUARD`. It stays low for `SCAN_DIV-GUARD` cycles, then all anodes go high for `GUARD` cycles.
- Capture to display latency: a value captured at a frame boundary appears on slot 0 at the `GUARD+1`-th edge after capture.
- Frame period is 4·`SCAN_DIV` cycles. Blink period is 2·`BLINK_FRAMES` frames.
- At most one anode is low at any time, and never two in consecutive cycles with different s.

## Structure
- Package `seg_pkg`:
  - `CODE_BLANK=4'hA`, `CODE_DASH=4'hB`;
  - the 7-bit glyph constants;
  - `SEG_OFF=7'b1111111`.
- Sub-module `seg_decode`: combinational 4-bit code → 7-bit active-low glyph. Instantiated once, fed by the shadow nibble muxed by `slot`.
- Top module holds the counters, shadow registers, guard/blink gating and output registers.

## Test plan
All scenarios use `SCAN_DIV=8`, `GUARD=2`, `BLINK_FRAMES=2`.

- **Reset:** hold `rst_n=0`, drive `nums=16'h1234` → `digit=4'hF`, `display=7'h7F`, `dp=1`. After release, the first frame (32 cycles) keeps all slots blank.
- **Scan order and guard:** `nums=16'h1234` stable → per slot: 2 cycles of `digit=4'hF`, then 6 cycles of `digit=4'hE` with glyph 4 (`7'b0011001`). Then slot 1 shows 3, slot 2 shows 2, slot 3 shows 1. Never two anodes low at once.
- **Frame-atomic capture:** change `nums` from `16'h1234` to `16'h5678` mid-slot 1 → slots 1–3 still show 3, 2, 1. The next frame shows 8, 7, 6, 5.
- **Special codes:** `nums=16'hAB0A` → slot 0 blank, slot 1 `7'b1000000`, slot 2 dash `7'b0111111`, slot 3 blank; anode still cycles.
- **Blink and dp:** `blink_mask=4'b0001`, `dp_mask=4'b0010` → slot 0 visible 2 frames, dark 2 frames, repeating. `dp=0` only during slot 1's active window.
- **Async reset mid-slot:** pulse `rst_n` low for 1 ns during an active slot → outputs go to reset values before the next edge. The shadow returns to `16'hAAAA`.
